topo_sort_scheduler: RTL and testbench

- Consumer end of the indegree list update interface. Drives node_sel/decrement_degree and reads node_degree to run Kahn's topological sort over a graph whose indegrees are already loaded.
- Scans all nodes for zero indegree, then pops ready nodes, walks their out-edges through an external adjacency store and decrements each successor.
- Emits the resulting node order as a stream and flags a cycle when not every node is emitted.

---
 rtl/topo_sort_pkg.sv | 10 +
 rtl/topo_sort_scheduler_ready_fifo.sv | 41 ++++
 rtl/topo_sort_scheduler.sv | 130 +++++++++++++
 tb/tb_topo_sort_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/topo_sort_pkg.sv
// topo_sort_pkg: shared widths, node/edge/count types and scheduler FSM states
package topo_sort_pkg;
  localparam int MAX_NODES = 1024;
  localparam int NODE_WIDTH = $clog2(MAX_NODES);
  localparam int EDGE_WIDTH = 12;
  typedef logic [NODE_WIDTH-1:0] node_t;
  typedef logic [EDGE_WIDTH-1:0] edge_t;
  typedef logic [NODE_WIDTH:0] count_t;
  typedef enum logic [2:0] {IDLE, SCAN, POP, OFFSET, EDGE_REQ, DECR, CHECK, DONE} state_t;
endpackage

// File: rtl/topo_sort_scheduler_ready_fifo.sv
// ready_fifo: node FIFO (push/din in, pop/dout/empty out), write-first registered read so dout always shows the head
module ready_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q;
  always_comb begin
    wr_d = push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = push ? cnt_q + 1'b1 : pop ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
    dout_q <= (push && wr_q == rd_d) ? din : mem[rd_d];
  end
  assign dout = dout_q;
  assign empty = cnt_q == '0;
endmodule

// File: rtl/topo_sort_scheduler.sv
// topo_sort_scheduler: Kahn topological sort over an indegree list (node_sel/decrement_degree/node_degree) and adjacency store (adj_*, edge_*), streaming order_* with busy/done/has_cycle
module topo_sort_scheduler #(
  parameter int MAX_NODES = topo_sort_pkg::MAX_NODES,
  parameter int NODE_WIDTH = $clog2(MAX_NODES),
  parameter int EDGE_WIDTH = topo_sort_pkg::EDGE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NODE_WIDTH:0]   node_count,
  output logic [NODE_WIDTH-1:0] node_sel,
  output logic                  decrement_degree,
  input  logic [NODE_WIDTH-1:0] node_degree,
  output logic                  adj_req,
  output logic [NODE_WIDTH-1:0] adj_node,
  input  logic [EDGE_WIDTH-1:0] adj_base,
  input  logic [NODE_WIDTH-1:0] adj_len,
  output logic                  edge_req,
  output logic [EDGE_WIDTH-1:0] edge_addr,
  input  logic [NODE_WIDTH-1:0] edge_dst,
  output logic                  order_valid,
  output logic [NODE_WIDTH-1:0] order_node,
  output logic                  busy,
  output logic                  done,
  output logic                  has_cycle
);
  import topo_sort_pkg::*;
  state_t state_q, state_d;
  logic [NODE_WIDTH:0] cnt_q, cnt_d, scan_q, scan_d, emit_q, emit_d, k_q, k_d;
  logic [EDGE_WIDTH-1:0] base_q, base_d;
  logic [NODE_WIDTH-1:0] len_q, len_d, dst_q, dst_d, push_node, head;
  logic push, pop, empty;
  ready_fifo #(.WIDTH(NODE_WIDTH), .DEPTH(MAX_NODES)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(push_node), .pop(pop), .dout(head), .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    scan_d = scan_q;
    emit_d = emit_q;
    k_d = k_q;
    base_d = base_q;
    len_d = len_q;
    dst_d = dst_q;
    push = 1'b0;
    pop = 1'b0;
    push_node = NODE_WIDTH'(scan_q - 1'b1);
    node_sel = '0;
    decrement_degree = 1'b0;
    adj_req = 1'b0;
    adj_node = '0;
    edge_req = 1'b0;
    edge_addr = '0;
    order_valid = 1'b0;
    order_node = '0;
    case (state_q)
      IDLE, DONE: if (start) begin
        cnt_d = node_count;
        emit_d = '0;
        scan_d = '0;
        state_d = node_count == '0 ? DONE : SCAN;
      end
      SCAN: begin
        node_sel = scan_q[NODE_WIDTH-1:0];
        scan_d = scan_q + 1'b1;
        push = scan_q != '0 && node_degree == '0;
        state_d = scan_q == cnt_q ? POP : SCAN;
      end
      POP: if (empty) state_d = DONE;
      else begin
        pop = 1'b1;
        order_valid = 1'b1;
        order_node = head;
        adj_req = 1'b1;
        adj_node = head;
        emit_d = emit_q + 1'b1;
        k_d = '0;
        state_d = OFFSET;
      end
      OFFSET: begin
        base_d = adj_base;
        len_d = adj_len;
        state_d = adj_len == '0 ? POP : EDGE_REQ;
      end
      EDGE_REQ: begin
        edge_req = 1'b1;
        edge_addr = base_q + EDGE_WIDTH'(k_q);
        state_d = DECR;
      end
      DECR: begin
        node_sel = edge_dst;
        decrement_degree = 1'b1;
        dst_d = edge_dst;
        state_d = CHECK;
      end
      CHECK: begin
        node_sel = dst_q;
        push = node_degree == '0;
        push_node = dst_q;
        k_d = k_q + 1'b1;
        state_d = (k_q + 1'b1 < {1'b0, len_q}) ? EDGE_REQ : POP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      scan_q <= '0;
      emit_q <= '0;
      k_q <= '0;
      base_q <= '0;
      len_q <= '0;
      dst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      scan_q <= scan_d;
      emit_q <= emit_d;
      k_q <= k_d;
      base_q <= base_d;
      len_q <= len_d;
      dst_q <= dst_d;
    end
  end
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign has_cycle = done && emit_q != cnt_q;
endmodule

// File: tb/tb_topo_sort_scheduler.sv
// tb_topo_sort_scheduler: random and directed graphs sorted by the DUT, compared against a queue-based Kahn model
module tb_topo_sort_scheduler;
  import topo_sort_pkg::*;
  logic clk = 0, rst = 1, start = 0, clr = 0;
  count_t node_count = '0;
  node_t node_sel, node_degree, adj_node, adj_len, edge_dst, order_node;
  edge_t adj_base, edge_addr;
  logic decrement_degree, adj_req, edge_req, order_valid, busy, done, has_cycle;
  int checks = 0, errors = 0;
  int init_deg[MAX_NODES], dec_cnt[MAX_NODES], cbase[MAX_NODES], clen[MAX_NODES], etab[4096];
  int esrc[4096], edst[4096], ne = 0;
  int got[$], expq[$];
  int exp_edges = 0, n_edge = 0, n_adj = 0;
  logic prev_dec = 0;
  always #5 clk = ~clk;
  topo_sort_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .node_count(node_count),
    .node_sel(node_sel), .decrement_degree(decrement_degree), .node_degree(node_degree),
    .adj_req(adj_req), .adj_node(adj_node), .adj_base(adj_base), .adj_len(adj_len),
    .edge_req(edge_req), .edge_addr(edge_addr), .edge_dst(edge_dst),
    .order_valid(order_valid), .order_node(order_node),
    .busy(busy), .done(done), .has_cycle(has_cycle)
  );
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < MAX_NODES; i++) dec_cnt[i] <= 0;
    else if (decrement_degree) dec_cnt[node_sel] <= dec_cnt[node_sel] + 1;
    node_degree <= decrement_degree ? node_t'(init_deg[node_sel] - dec_cnt[node_sel] - 1)
                                    : node_t'(init_deg[node_sel] - dec_cnt[node_sel]);
    adj_base <= edge_t'(cbase[adj_node]);
    adj_len <= node_t'(clen[adj_node]);
    edge_dst <= node_t'(etab[edge_addr]);
  end
  always @(negedge clk) begin
    if (order_valid) got.push_back(int'(order_node));
    if (edge_req) n_edge <= n_edge + 1;
    if (decrement_degree && prev_dec) n_adj <= n_adj + 1;
    prev_dec <= decrement_degree;
  end
  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  task automatic add(input int s, input int d);
    esrc[ne] = s;
    edst[ne] = d;
    ne++;
  endtask
  task automatic prep(input int n);
    int deg[MAX_NODES];
    int pos[MAX_NODES];
    int q[$];
    int acc, u;
    for (int v = 0; v < MAX_NODES; v++) begin
      clen[v] = 0;
      init_deg[v] = 0;
    end
    for (int e = 0; e < ne; e++) begin
      clen[esrc[e]]++;
      init_deg[edst[e]]++;
    end
    acc = 0;
    for (int v = 0; v < MAX_NODES; v++) begin
      cbase[v] = acc;
      pos[v] = acc;
      acc += clen[v];
    end
    for (int e = 0; e < ne; e++) begin
      etab[pos[esrc[e]]] = edst[e];
      pos[esrc[e]]++;
    end
    @(negedge clk) clr = 1;
    @(negedge clk) clr = 0;
    expq.delete();
    exp_edges = 0;
    for (int v = 0; v < n; v++) deg[v] = init_deg[v];
    for (int v = 0; v < n; v++) if (deg[v] == 0) q.push_back(v);
    while (q.size() > 0) begin
      u = q.pop_front();
      expq.push_back(u);
      for (int e = 0; e < ne; e++) if (esrc[e] == u) begin
        exp_edges++;
        deg[edst[e]]--;
        if (deg[edst[e]] == 0) q.push_back(edst[e]);
      end
    end
  endtask
  task automatic run(input string name, input int n);
    int g0, e0, a0, cyc;
    prep(n);
    g0 = got.size();
    e0 = n_edge;
    a0 = n_adj;
    node_count = count_t'(n);
    start = 1;
    @(negedge clk) start = 0;
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " done"}, int'(done), 1);
    if (n == 0) check({name, " done_latency_ok"}, int'(cyc <= 2), 1);
    check({name, " busy"}, int'(busy), 0);
    check({name, " has_cycle"}, int'(has_cycle), int'(expq.size() != n));
    check({name, " emitted"}, got.size() - g0, expq.size());
    for (int i = 0; i < expq.size(); i++)
      check($sformatf("%s order[%0d]", name, i), (g0 + i < got.size()) ? got[g0 + i] : -1, expq[i]);
    check({name, " edge_reqs"}, n_edge - e0, exp_edges);
    check({name, " adjacent_decrements"}, n_adj - a0, 0);
  endtask
  task automatic diamond();
    ne = 0;
    add(0, 1);
    add(0, 2);
    add(1, 3);
    add(2, 3);
  endtask
  initial begin
    int n, cyc, perm[MAX_NODES], a, b, t;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset has_cycle", int'(has_cycle), 0);
    check("reset order_valid", int'(order_valid), 0);
    check("reset node_sel", int'(node_sel), 0);
    check("reset decrement", int'(decrement_degree), 0);
    check("reset adj_req", int'(adj_req), 0);
    check("reset edge_req", int'(edge_req), 0);
    ne = 0;
    add(0, 1);
    add(1, 2);
    run("chain", 3);
    diamond();
    run("diamond", 4);
    ne = 0;
    add(0, 1);
    add(1, 2);
    add(2, 1);
    run("cycle", 3);
    ne = 0;
    run("empty", 0);
    run("isolated", 4);
    diamond();
    prep(4);
    node_count = 4;
    start = 1;
    @(negedge clk) start = 0;
    cyc = 0;
    while (!decrement_degree && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid decr_seen", int'(decrement_degree), 1);
    rst = 1;
    @(negedge clk);
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid decrement", int'(decrement_degree), 0);
    check("rst_mid node_sel", int'(node_sel), 0);
    check("rst_mid order_valid", int'(order_valid), 0);
    check("rst_mid edge_req", int'(edge_req), 0);
    check("rst_mid done", int'(done), 0);
    rst = 0;
    run("diamond_after_rst", 4);
    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(1, 20);
      ne = 0;
      for (int i = 0; i < n; i++) perm[i] = i;
      for (int i = n - 1; i > 0; i--) begin
        a = $urandom_range(0, i);
        t = perm[i];
        perm[i] = perm[a];
        perm[a] = t;
      end
      for (int e = $urandom_range(0, 2 * n); e > 0; e--)
        if (r % 3 == 2) add($urandom_range(0, n - 1), $urandom_range(0, n - 1));
        else if (n > 1) begin
          a = $urandom_range(0, n - 2);
          b = $urandom_range(a + 1, n - 1);
          add(perm[a], perm[b]);
        end
      run($sformatf("rand%0d", r), n);
    end
    n = MAX_NODES;
    ne = 0;
    for (int e = 0; e < 3000; e++) begin
      a = $urandom_range(0, n - 2);
      b = $urandom_range(a + 1, n - 1);
      add(a, b);
    end
    run("full_dag", n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
